// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to two of three execution results per cycle into
// two registered regfile/scoreboard slots, and turns the oldest redirect into a flush.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 3
`endif

module wb_arbiter (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              alu0_valid_i,
   output logic                              alu0_ready_o,
   input  logic                              alu0_rd_wen_i,
   input  logic [4:0]                        alu0_rd_i,
   input  logic [63:0]                       alu0_value_i,
   input  logic [`SCOREBOARD_SIZE_WIDTH:0]   alu0_sid_i,
   input  logic                              alu0_redirect_i,
   input  logic [63:0]                       alu0_redirect_pc_i,
   input  logic                              alu1_valid_i,
   output logic                              alu1_ready_o,
   input  logic                              alu1_rd_wen_i,
   input  logic [4:0]                        alu1_rd_i,
   input  logic [63:0]                       alu1_value_i,
   input  logic [`SCOREBOARD_SIZE_WIDTH:0]   alu1_sid_i,
   input  logic                              alu1_redirect_i,
   input  logic [63:0]                       alu1_redirect_pc_i,
   input  logic                              lsu_valid_i,
   output logic                              lsu_ready_o,
   input  logic                              lsu_rd_wen_i,
   input  logic [4:0]                        lsu_rd_i,
   input  logic [63:0]                       lsu_value_i,
   input  logic [`SCOREBOARD_SIZE_WIDTH:0]   lsu_sid_i,
   input  logic                              lsu_redirect_i,
   input  logic [63:0]                       lsu_redirect_pc_i,
   output logic                              inst0_wb_valid_o,
   output logic [4:0]                        inst0_wb_rd_o,
   output logic [63:0]                       inst0_wb_value_o,
   output logic                              inst0_wb_done_o,
   output logic [`SCOREBOARD_SIZE_WIDTH:0]   inst0_wb_sid_o,
   output logic                              inst1_wb_valid_o,
   output logic [4:0]                        inst1_wb_rd_o,
   output logic [63:0]                       inst1_wb_value_o,
   output logic                              inst1_wb_done_o,
   output logic [`SCOREBOARD_SIZE_WIDTH:0]   inst1_wb_sid_o,
   output logic                              flush_o,
   output logic [63:0]                       redirect_pc_o
);

   localparam int SW = `SCOREBOARD_SIZE_WIDTH + 1;

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      ptr_reg, ptr_next;
   logic [63:0]     redirect_pc_reg, redirect_pc_next;
   logic            take_redirect;

   logic [2:0]      p_valid, p_wen, p_redir, ready;
   logic [4:0]      p_rd    [3];
   logic [63:0]     p_value [3];
   logic [SW-1:0]   p_sid   [3];
   logic [63:0]     p_pc    [3];

   logic [1:0]      slot_sel [2];
   logic [1:0]      slot_gnt, slot_kill, slot_done;
   logic [1:0]      o0, o1, o2;
   logic            run, s0_older, r0, r1;

   logic [1:0]      wb_valid_reg, wb_done_reg;
   logic [4:0]      wb_rd_reg    [2];
   logic [63:0]     wb_value_reg [2];
   logic [SW-1:0]   wb_sid_reg   [2];

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // The wrap bit flips each lap of the scoreboard, inverting the sense of the low compare.
   function automatic logic older(input logic [SW-1:0] a, input logic [SW-1:0] b);
      if (a[SW-1] == b[SW-1]) return a[SW-2:0] < b[SW-2:0];
      else                    return a[SW-2:0] > b[SW-2:0];
   endfunction

   always_comb begin
      p_valid = {lsu_valid_i, alu1_valid_i, alu0_valid_i};
      p_wen   = {lsu_rd_wen_i, alu1_rd_wen_i, alu0_rd_wen_i};
      p_redir = {lsu_redirect_i, alu1_redirect_i, alu0_redirect_i};
      p_rd[0] = alu0_rd_i;           p_rd[1] = alu1_rd_i;           p_rd[2] = lsu_rd_i;
      p_value[0] = alu0_value_i;     p_value[1] = alu1_value_i;     p_value[2] = lsu_value_i;
      p_sid[0] = alu0_sid_i;         p_sid[1] = alu1_sid_i;         p_sid[2] = lsu_sid_i;
      p_pc[0] = alu0_redirect_pc_i;  p_pc[1] = alu1_redirect_pc_i;  p_pc[2] = lsu_redirect_pc_i;
   end

   assign run = (state_reg == ST_RUN);

   always_comb begin
      o0 = ptr_reg;
      o1 = inc3(ptr_reg);
      o2 = inc3(o1);
      slot_gnt    = 2'b00;
      slot_sel[0] = o0;
      slot_sel[1] = o1;
      if (p_valid[o0]) begin
         slot_gnt[0] = 1'b1;
         slot_sel[0] = o0;
         if (p_valid[o1]) begin
            slot_gnt[1] = 1'b1;
            slot_sel[1] = o1;
         end else if (p_valid[o2]) begin
            slot_gnt[1] = 1'b1;
            slot_sel[1] = o2;
         end
      end else if (p_valid[o1]) begin
         slot_gnt[0] = 1'b1;
         slot_sel[0] = o1;
         if (p_valid[o2]) begin
            slot_gnt[1] = 1'b1;
            slot_sel[1] = o2;
         end
      end else if (p_valid[o2]) begin
         slot_gnt[0] = 1'b1;
         slot_sel[0] = o2;
      end
   end

   always_comb begin
      s0_older         = older(p_sid[slot_sel[0]], p_sid[slot_sel[1]]);
      r0               = slot_gnt[0] && p_redir[slot_sel[0]];
      r1               = slot_gnt[1] && p_redir[slot_sel[1]];
      slot_kill        = 2'b00;
      redirect_pc_next = p_pc[slot_sel[0]];
      if (r0 && (!r1 || s0_older)) begin
         slot_kill[1] = slot_gnt[1] && s0_older;
      end else if (r1) begin
         slot_kill[0]     = slot_gnt[0] && !s0_older;
         redirect_pc_next = p_pc[slot_sel[1]];
      end
      take_redirect = run && (r0 || r1);
   end

   always_comb begin
      ready = 3'b000;
      if (!run) begin
         ready = 3'b111;
      end else begin
         if (slot_gnt[0]) ready[slot_sel[0]] = 1'b1;
         if (slot_gnt[1]) ready[slot_sel[1]] = 1'b1;
      end
      if (rst) ready = 3'b000;
   end

   assign {lsu_ready_o, alu1_ready_o, alu0_ready_o} = ready;

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      if (!run) begin
         state_next = ST_RUN;
      end else begin
         if (take_redirect) state_next = ST_FLUSH;
         if (&p_valid)      ptr_next   = inc3(ptr_reg);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_RUN;
         ptr_reg         <= 2'd0;
         redirect_pc_reg <= 64'd0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         if (take_redirect) redirect_pc_reg <= redirect_pc_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         assign slot_done[gi] = run && slot_gnt[gi] && !slot_kill[gi];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wb_done_reg[gi]  <= 1'b0;
               wb_valid_reg[gi] <= 1'b0;
               wb_rd_reg[gi]    <= 5'd0;
               wb_value_reg[gi] <= 64'd0;
               wb_sid_reg[gi]   <= '0;
            end else begin
               wb_done_reg[gi]  <= slot_done[gi];
               wb_valid_reg[gi] <= slot_done[gi] && p_wen[slot_sel[gi]] && (p_rd[slot_sel[gi]] != 5'd0);
               if (slot_done[gi]) begin
                  wb_rd_reg[gi]    <= p_rd[slot_sel[gi]];
                  wb_value_reg[gi] <= p_value[slot_sel[gi]];
                  wb_sid_reg[gi]   <= p_sid[slot_sel[gi]];
               end
            end
         end
      end
   endgenerate

   assign inst0_wb_valid_o = wb_valid_reg[0];
   assign inst0_wb_done_o  = wb_done_reg[0];
   assign inst0_wb_rd_o    = wb_rd_reg[0];
   assign inst0_wb_value_o = wb_value_reg[0];
   assign inst0_wb_sid_o   = wb_sid_reg[0];
   assign inst1_wb_valid_o = wb_valid_reg[1];
   assign inst1_wb_done_o  = wb_done_reg[1];
   assign inst1_wb_rd_o    = wb_rd_reg[1];
   assign inst1_wb_value_o = wb_value_reg[1];
   assign inst1_wb_sid_o   = wb_sid_reg[1];
   assign flush_o          = (state_reg == ST_FLUSH);
   assign redirect_pc_o    = redirect_pc_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Vector table of offered results with hand-derived grants; expected writeback
// records are queued at drive time and popped one cycle later.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 3
`endif

module tb_wb_arbiter;

   localparam int SW = `SCOREBOARD_SIZE_WIDTH + 1;
   localparam int NV = 16;

   logic clk, rst;
   logic alu0_valid_i, alu0_ready_o, alu0_rd_wen_i, alu0_redirect_i;
   logic alu1_valid_i, alu1_ready_o, alu1_rd_wen_i, alu1_redirect_i;
   logic lsu_valid_i, lsu_ready_o, lsu_rd_wen_i, lsu_redirect_i;
   logic [4:0] alu0_rd_i, alu1_rd_i, lsu_rd_i;
   logic [63:0] alu0_value_i, alu1_value_i, lsu_value_i;
   logic [63:0] alu0_redirect_pc_i, alu1_redirect_pc_i, lsu_redirect_pc_i;
   logic [SW-1:0] alu0_sid_i, alu1_sid_i, lsu_sid_i;
   logic inst0_wb_valid_o, inst0_wb_done_o, inst1_wb_valid_o, inst1_wb_done_o, flush_o;
   logic [4:0] inst0_wb_rd_o, inst1_wb_rd_o;
   logic [63:0] inst0_wb_value_o, inst1_wb_value_o, redirect_pc_o;
   logic [SW-1:0] inst0_wb_sid_o, inst1_wb_sid_o;

   wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu0_valid_i(alu0_valid_i), .alu0_ready_o(alu0_ready_o), .alu0_rd_wen_i(alu0_rd_wen_i),
      .alu0_rd_i(alu0_rd_i), .alu0_value_i(alu0_value_i), .alu0_sid_i(alu0_sid_i),
      .alu0_redirect_i(alu0_redirect_i), .alu0_redirect_pc_i(alu0_redirect_pc_i),
      .alu1_valid_i(alu1_valid_i), .alu1_ready_o(alu1_ready_o), .alu1_rd_wen_i(alu1_rd_wen_i),
      .alu1_rd_i(alu1_rd_i), .alu1_value_i(alu1_value_i), .alu1_sid_i(alu1_sid_i),
      .alu1_redirect_i(alu1_redirect_i), .alu1_redirect_pc_i(alu1_redirect_pc_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_wen_i(lsu_rd_wen_i),
      .lsu_rd_i(lsu_rd_i), .lsu_value_i(lsu_value_i), .lsu_sid_i(lsu_sid_i),
      .lsu_redirect_i(lsu_redirect_i), .lsu_redirect_pc_i(lsu_redirect_pc_i),
      .inst0_wb_valid_o(inst0_wb_valid_o), .inst0_wb_rd_o(inst0_wb_rd_o),
      .inst0_wb_value_o(inst0_wb_value_o), .inst0_wb_done_o(inst0_wb_done_o),
      .inst0_wb_sid_o(inst0_wb_sid_o),
      .inst1_wb_valid_o(inst1_wb_valid_o), .inst1_wb_rd_o(inst1_wb_rd_o),
      .inst1_wb_value_o(inst1_wb_value_o), .inst1_wb_done_o(inst1_wb_done_o),
      .inst1_wb_sid_o(inst1_wb_sid_o),
      .flush_o(flush_o), .redirect_pc_o(redirect_pc_o)
   );

   typedef struct {
      logic [2:0]         vld, wen, red;
      logic [2:0][4:0]    rd;
      logic [2:0][SW-1:0] sid;
      logic [2:0]         erdy;
      logic [1:0]         ed, ev;
      logic [1:0]         es0, es1;
      logic               efl;
      logic [1:0]         epc;
   } vec_t;

   typedef struct {
      logic [1:0]         v, d;
      logic [1:0][4:0]    rd;
      logic [1:0][63:0]   val;
      logic [1:0][SW-1:0] sid;
      logic               fl;
      logic [63:0]        pc;
   } exp_t;

   vec_t tbl [NV];
   exp_t sb [$];
   int   checks = 0;
   int   failures = 0;
   logic [63:0] last_pc;
   logic [2:0]  rdy;

   assign rdy = {lsu_ready_o, alu1_ready_o, alu0_ready_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] wen, input logic [2:0] red,
                               input logic [14:0] rd, input logic [3*SW-1:0] sid,
                               input logic [2:0] erdy, input logic [1:0] ed, input logic [1:0] ev,
                               input logic [1:0] es0, input logic [1:0] es1,
                               input logic efl, input logic [1:0] epc);
      vec_t v;
      v.vld = vld; v.wen = wen; v.red = red; v.rd = rd; v.sid = sid;
      v.erdy = erdy; v.ed = ed; v.ev = ev; v.es0 = es0; v.es1 = es1; v.efl = efl; v.epc = epc;
      return v;
   endfunction

   function automatic logic [63:0] val_of(input int i, input int p);
      if (i == 0 && p == 0) return 64'h1234;
      return 64'hDEAD_0000_0000_0000 | (64'(i) << 8) | 64'(p);
   endfunction

   function automatic logic [63:0] pc_of(input int p);
      return 64'h8000_0000 + 64'(p + 1) * 64'h100;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input int i);
      alu0_valid_i = v.vld[0]; alu0_rd_wen_i = v.wen[0]; alu0_redirect_i = v.red[0];
      alu0_rd_i = v.rd[0]; alu0_sid_i = v.sid[0];
      alu0_value_i = val_of(i, 0); alu0_redirect_pc_i = pc_of(0);
      alu1_valid_i = v.vld[1]; alu1_rd_wen_i = v.wen[1]; alu1_redirect_i = v.red[1];
      alu1_rd_i = v.rd[1]; alu1_sid_i = v.sid[1];
      alu1_value_i = val_of(i, 1); alu1_redirect_pc_i = pc_of(1);
      lsu_valid_i = v.vld[2]; lsu_rd_wen_i = v.wen[2]; lsu_redirect_i = v.red[2];
      lsu_rd_i = v.rd[2]; lsu_sid_i = v.sid[2];
      lsu_value_i = val_of(i, 2); lsu_redirect_pc_i = pc_of(2);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_done0"}, 64'(inst0_wb_done_o), 64'd0);
      chk({nm, "_valid0"}, 64'(inst0_wb_valid_o), 64'd0);
      chk({nm, "_done1"}, 64'(inst1_wb_done_o), 64'd0);
      chk({nm, "_valid1"}, 64'(inst1_wb_valid_o), 64'd0);
      chk({nm, "_flush"}, 64'(flush_o), 64'd0);
      chk({nm, "_rd0"}, 64'(inst0_wb_rd_o), 64'd0);
      chk({nm, "_value0"}, inst0_wb_value_o, 64'd0);
      chk({nm, "_sid0"}, 64'(inst0_wb_sid_o), 64'd0);
      chk({nm, "_pc"}, redirect_pc_o, 64'd0);
   endtask

   vec_t zv, dv;
   exp_t e, got;

   initial begin
      //                 vld     wen     red     rd{lsu,alu1,alu0}     sid{lsu,alu1,alu0}       rdy     ed     ev     s0 s1 fl pc
      tbl[0]  = mk(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd5},    {4'd0, 4'd0, 4'd3},       3'b001, 2'b01, 2'b01, 0, 0, 0, 0);
      tbl[1]  = mk(3'b111, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1},    {4'd4, 4'd2, 4'd1},       3'b011, 2'b11, 2'b11, 0, 1, 0, 0);
      tbl[2]  = mk(3'b111, 3'b111, 3'b000, {5'd8, 5'd7, 5'd6},    {4'd7, 4'd6, 4'd5},       3'b110, 2'b11, 2'b11, 1, 2, 0, 0);
      tbl[3]  = mk(3'b111, 3'b111, 3'b000, {5'd11, 5'd10, 5'd9},  {4'd2, 4'd1, 4'd0},       3'b101, 2'b11, 2'b11, 2, 0, 0, 0);
      tbl[4]  = mk(3'b100, 3'b100, 3'b000, {5'd0, 5'd0, 5'd0},    {4'd9, 4'd0, 4'd0},       3'b100, 2'b01, 2'b00, 2, 0, 0, 0);
      tbl[5]  = mk(3'b110, 3'b100, 3'b000, {5'd12, 5'd0, 5'd0},   {4'd2, 4'd1, 4'd0},       3'b110, 2'b11, 2'b10, 1, 2, 0, 0);
      tbl[6]  = mk(3'b111, 3'b111, 3'b000, {5'd15, 5'd14, 5'd13}, {4'd3, 4'd4, 4'd5},       3'b011, 2'b11, 2'b11, 0, 1, 0, 0);
      tbl[7]  = mk(3'b101, 3'b101, 3'b000, {5'd17, 5'd0, 5'd16},  {4'd6, 4'd0, 4'd7},       3'b101, 2'b11, 2'b11, 2, 0, 0, 0);
      tbl[8]  = mk(3'b011, 3'b011, 3'b011, {5'd0, 5'd21, 5'd20},  {4'd0, 4'b0110, 4'b1001}, 3'b011, 2'b01, 2'b01, 1, 0, 1, 1);
      tbl[9]  = mk(3'b101, 3'b101, 3'b000, {5'd3, 5'd0, 5'd2},    {4'd1, 4'd0, 4'd2},       3'b111, 2'b00, 2'b00, 0, 0, 0, 0);
      tbl[10] = mk(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd4},    {4'd0, 4'd0, 4'd2},       3'b001, 2'b01, 2'b01, 0, 0, 0, 0);
      tbl[11] = mk(3'b101, 3'b101, 3'b001, {5'd22, 5'd0, 5'd23},  {4'd2, 4'd0, 4'd3},       3'b101, 2'b11, 2'b11, 2, 0, 1, 0);
      tbl[12] = mk(3'b000, 3'b000, 3'b000, {5'd0, 5'd0, 5'd0},    {4'd0, 4'd0, 4'd0},       3'b111, 2'b00, 2'b00, 0, 0, 0, 0);
      tbl[13] = mk(3'b110, 3'b110, 3'b010, {5'd25, 5'd24, 5'd0},  {4'd5, 4'd4, 4'd0},       3'b110, 2'b01, 2'b01, 1, 2, 1, 1);
      tbl[14] = mk(3'b000, 3'b000, 3'b000, {5'd0, 5'd0, 5'd0},    {4'd0, 4'd0, 4'd0},       3'b111, 2'b00, 2'b00, 0, 0, 0, 0);
      tbl[15] = mk(3'b000, 3'b000, 3'b000, {5'd0, 5'd0, 5'd0},    {4'd0, 4'd0, 4'd0},       3'b000, 2'b00, 2'b00, 0, 0, 0, 0);
      zv = tbl[15];

      // Reset: ready stays low even with a result offered.
      rst = 1'b1;
      dv = mk(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, {4'd0, 4'd0, 4'd1}, 0, 0, 0, 0, 0, 0, 0);
      drive(dv, 50);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 64'(rdy), 64'd0);
      chk_idle("reset");
      rst = 1'b0;
      drive(zv, 51);
      last_pc = 64'd0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i], i);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(rdy), 64'(tbl[i].erdy));
         e.v = tbl[i].ev;
         e.d = tbl[i].ed;
         e.rd[0] = tbl[i].rd[tbl[i].es0];   e.rd[1] = tbl[i].rd[tbl[i].es1];
         e.sid[0] = tbl[i].sid[tbl[i].es0]; e.sid[1] = tbl[i].sid[tbl[i].es1];
         e.val[0] = val_of(i, int'(tbl[i].es0));
         e.val[1] = val_of(i, int'(tbl[i].es1));
         e.fl = tbl[i].efl;
         if (tbl[i].efl) last_pc = pc_of(int'(tbl[i].epc));
         e.pc = last_pc;
         sb.push_back(e);
         @(posedge clk);
         #1;
         got = sb.pop_front();
         chk($sformatf("v%0d_done0", i), 64'(inst0_wb_done_o), 64'(got.d[0]));
         chk($sformatf("v%0d_valid0", i), 64'(inst0_wb_valid_o), 64'(got.v[0]));
         chk($sformatf("v%0d_done1", i), 64'(inst1_wb_done_o), 64'(got.d[1]));
         chk($sformatf("v%0d_valid1", i), 64'(inst1_wb_valid_o), 64'(got.v[1]));
         if (got.d[0]) begin
            chk($sformatf("v%0d_rd0", i), 64'(inst0_wb_rd_o), 64'(got.rd[0]));
            chk($sformatf("v%0d_value0", i), inst0_wb_value_o, got.val[0]);
            chk($sformatf("v%0d_sid0", i), 64'(inst0_wb_sid_o), 64'(got.sid[0]));
         end
         if (got.d[1]) begin
            chk($sformatf("v%0d_rd1", i), 64'(inst1_wb_rd_o), 64'(got.rd[1]));
            chk($sformatf("v%0d_value1", i), inst1_wb_value_o, got.val[1]);
            chk($sformatf("v%0d_sid1", i), 64'(inst1_wb_sid_o), 64'(got.sid[1]));
         end
         chk($sformatf("v%0d_flush", i), 64'(flush_o), 64'(got.fl));
         chk($sformatf("v%0d_pc", i), redirect_pc_o, got.pc);
         $display("TXN %0d vld=%b ready=%b done=%b%b valid=%b%b flush=%b pc=%0h", i, tbl[i].vld,
                  tbl[i].erdy, inst1_wb_done_o, inst0_wb_done_o, inst1_wb_valid_o,
                  inst0_wb_valid_o, flush_o, redirect_pc_o);
      end

      // Redirect into FLUSH, then reset in the middle of the flush cycle.
      dv = mk(3'b001, 3'b001, 3'b001, {5'd0, 5'd0, 5'd9}, {4'd0, 4'd0, 4'd1}, 0, 0, 0, 0, 0, 0, 0);
      drive(dv, 60);
      #1;
      chk("rf_ready", 64'(rdy), 64'b001);
      @(posedge clk);
      #1;
      chk("rf_flush_up", 64'(flush_o), 64'd1);
      chk("rf_done0", 64'(inst0_wb_done_o), 64'd1);
      dv.red = 3'b000;
      drive(dv, 61);
      #1;
      rst = 1'b1;
      #1;
      chk("rf_ready_in_reset", 64'(rdy), 64'd0);
      chk_idle("rf_async");
      $display("TXN reset_in_flush flush=%b ready=%b", flush_o, rdy);
      @(posedge clk);
      #1;
      rst = 1'b0;
      dv = mk(3'b111, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {4'd3, 4'd2, 4'd1}, 0, 0, 0, 0, 0, 0, 0);
      drive(dv, 62);
      #1;
      chk("rf_run_ready", 64'(rdy), 64'b011);
      chk_idle("rf_release");
      @(posedge clk);
      #1;
      chk("rf_after_done0", 64'(inst0_wb_done_o), 64'd1);
      chk("rf_after_sid0", 64'(inst0_wb_sid_o), 64'd1);
      chk("rf_after_done1", 64'(inst1_wb_done_o), 64'd1);
      chk("rf_after_sid1", 64'(inst1_wb_sid_o), 64'd2);
      chk("rf_after_flush", 64'(flush_o), 64'd0);
      $display("TXN after_reset done=%b%b sid0=%0d sid1=%0d", inst1_wb_done_o, inst0_wb_done_o,
               inst0_wb_sid_o, inst1_wb_sid_o);
      drive(zv, 63);
      @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
